hilo_muldiv: RTL and testbench
==============================

# hilo_muldiv

Iterative multiply/divide unit with the architectural HI/LO registers. It sits directly downstream of the register file and consumes the two registered read buses. It executes MULT/MULTU/DIV/DIVU over 34 cycles and MTHI/MTLO in one cycle, and presents HI/LO continuously for MFHI/MFLO. The controller stalls issue while `o_busy` is high.

## Interface
- No parameters. Data width is fixed at 32 bits and the iteration count is fixed at 32.
- `i_clk`  in  1  rising-edge clock.
- `i_arstn`  in  1  asynchronous, active-low reset.
- `i_start`  in  1  request. Sampled on an edge only while in IDLE.
- `i_op`  in  3  operation select:
  - 000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO.
  - 110 and 111 are reserved and ignored (no state change).
- `i_bus_a`  in  32  rs operand (register-file bus A). Multiplicand, dividend, or MTHI/MTLO source.
- `i_bus_b`  in  32  rt operand (register-file bus B). Multiplier or divisor.
- `o_busy`  out  1  high whenever the state is not IDLE (decoded from the state register).
- `o_done`  out  1  registered. One-cycle pulse after HI/LO are updated by a mult or div.
- `o_dz`  out  1  registered. Divide-by-zero flag, valid only in the `o_done` cycle, 0 otherwise.
- `o_hi`  out  32  HI register.
- `o_lo`  out  32  LO register.

## Operation
- Reset (async, `i_arstn`=0) forces, immediately and regardless of the clock:
  - state to IDLE, counter to 0;
  - `o_hi`, `o_lo` and all internal datapath registers to 0;
  - `o_busy`=0, `o_done`=0, `o_dz`=0.
- States: IDLE -> CALC -> FINISH -> IDLE.
- IDLE with `i_start`=1:
  - MTHI: HI <= `i_bus_a`, stay in IDLE, no `o_done` pulse.
  - MTLO: LO <= `i_bus_a`, stay in IDLE, no `o_done` pulse.
  - Mult/div ops: latch magnitudes of a and b (signed ops take |x|; unsigned ops take the raw value), latch the result-sign bits and the op. Counter <= 0, go to CALC.
  - Reserved op: nothing changes.
- CALC runs one iteration per edge, counter 0..31. After the edge where counter=31, go to FINISH.
  - Multiply: 64-bit shift-add. If the product LSB is set, add the multiplicand into the upper 33 bits, then shift right by 1.
  - Divide: restoring division. Shift {rem,quo} left by 1, trial-subtract the divisor from the 33-bit remainder, and keep the result if it is non-negative with quotient bit = 1.
- FINISH (one edge) writes HI/LO, sets `o_done`=1, and returns to IDLE.
  - MULT: 64-bit product, negated if sign(a)!=sign(b). HI = bits[63:32], LO = bits[31:0].
  - MULTU: raw 64-bit product.
  - DIV: LO = quotient, negated if signs differ. HI = remainder, taking the sign of the dividend.
  - DIVU: LO = quotient, HI = remainder, no sign fix.
  - Divisor = 0 (DIV or DIVU): LO = 0xFFFFFFFF, HI = `i_bus_a` value as latched (raw), `o_dz`=1. Sign fix is bypassed.
  - DIV 0x80000000 / 0xFFFFFFFF: LO = 0x80000000, HI = 0, `o_dz`=0.
- `i_start` while `o_busy`=1 is ignored. The unit is not re-entrant and there is no abort.
- HI/LO hold their values outside the FINISH and MTHI/MTLO write edges.

## Timing
- Accept edge E0 is the edge where IDLE and `i_start`=1 are sampled. Operands are sampled at E0 only, so `i_bus_a`/`i_bus_b` may change afterwards.
- `o_busy` is high from after E0 until after E33 (33 cycles).
- CALC occupies edges E1..E32. E33 is the FINISH edge.
- After E33: `o_hi`/`o_lo` hold the new result, `o_done`=1 and `o_dz` is valid for exactly one cycle, and `o_busy`=0.
- A new `i_start` is accepted on E34 at the earliest. A start in the `o_done` cycle is legal.
- MTHI/MTLO: the value is visible one cycle after the accept edge. `o_busy` never rises.
- The register-file read buses are registered, so the controller asserts `i_start` one cycle after presenting rs/rt addresses.
- Reset asserted mid-CALC aborts the operation: all outputs return to reset values and no `o_done` is produced.

## Test plan
- MULT a=0xFFFFFFFF, b=0x00000002 -> after E33: HI=0xFFFFFFFF, LO=0xFFFFFFFE, `o_done` pulse of width 1, `o_busy` high for exactly 33 cycles. MULTU with the same operands -> HI=0x00000001, LO=0xFFFFFFFE.
- DIV a=0xFFFFFFF9 (-7), b=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU a=100, b=7 -> LO=14, HI=2.
- DIVU a=0x12345678, b=0 -> LO=0xFFFFFFFF, HI=0x12345678, `o_dz`=1 in the `o_done` cycle only. DIV 0x80000000/0xFFFFFFFF -> LO=0x80000000, HI=0, `o_dz`=0.
- MTHI 0xDEADBEEF, then MTLO 0x0BADF00D on consecutive cycles -> each visible one cycle later, `o_busy` and `o_done` stay 0. Reserved op 111 -> no change.
- Start MULT, pulse `i_start` with a different op at cycle 10, and change the buses mid-CALC -> the request is ignored and the result matches the E0 operands.
- Assert `i_arstn`=0 at cycle 15 of a DIVU -> `o_hi`=`o_lo`=0 and `o_busy`=0 immediately. After release, no `o_done` appears and a new op completes normally.

Source files
------------

// File: rtl/hilo_muldiv.sv
// Iterative 32-bit multiply/divide unit that holds the architectural HI/LO registers.
// MULT/MULTU/DIV/DIVU take 34 edges in total; MTHI/MTLO write in one edge and never raise o_busy.
module hilo_muldiv (
  input  logic        i_clk,
  input  logic        i_arstn,
  input  logic        i_start,
  input  logic [2:0]  i_op,
  input  logic [31:0] i_bus_a,
  input  logic [31:0] i_bus_b,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_dz,
  output logic [31:0] o_hi,
  output logic [31:0] o_lo
);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FINISH} state_t;
  typedef struct packed {
    logic is_div;
    logic neg_q;   // negate product or quotient
    logic neg_r;   // negate remainder (sign of dividend)
  } ctl_t;

  localparam logic [2:0] OP_MTHI = 3'b100;
  localparam logic [2:0] OP_MTLO = 3'b101;

  state_t      state, state_nxt;
  logic [4:0]  cnt;
  logic [64:0] acc;     // mult: {upper33, multiplier}; div: {rem33, quotient}
  logic [31:0] opnd;    // multiplicand or divisor magnitude
  logic [31:0] a_raw;
  ctl_t        ctl;

  // Operand decode at accept time
  logic        is_md, is_sgn, a_neg, b_neg;
  logic [31:0] a_mag, b_mag;
  ctl_t        ctl_in;

  always_comb begin
    is_md  = ~i_op[2];
    is_sgn = ~i_op[0];
    a_neg  = is_sgn & i_bus_a[31];
    b_neg  = is_sgn & i_bus_b[31];
    a_mag  = a_neg ? (32'd0 - i_bus_a) : i_bus_a;
    b_mag  = b_neg ? (32'd0 - i_bus_b) : i_bus_b;
    ctl_in = '{is_div: i_op[1], neg_q: a_neg ^ b_neg, neg_r: a_neg};
  end

  // One iteration of shift-add multiply or restoring divide
  logic [32:0] sum, trial;
  logic [64:0] acc_step;

  always_comb begin
    sum   = acc[64:32] + {1'b0, opnd};
    trial = acc[63:31] - {1'b0, opnd};
    if (ctl.is_div)
      acc_step = trial[32] ? {acc[63:0], 1'b0} : {trial, acc[30:0], 1'b1};
    else
      acc_step = acc[0] ? {1'b0, sum, acc[31:1]} : {1'b0, acc[64:1]};
  end

  // Result sign fix-up
  logic [63:0] mult_res;
  logic [31:0] q_fix, r_fix;
  logic        dz;

  always_comb begin
    mult_res = ctl.neg_q ? (64'd0 - acc[63:0]) : acc[63:0];
    q_fix    = ctl.neg_q ? (32'd0 - acc[31:0]) : acc[31:0];
    r_fix    = ctl.neg_r ? (32'd0 - acc[63:32]) : acc[63:32];
    dz       = ctl.is_div && (opnd == 32'd0);
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (i_start && is_md) state_nxt = S_CALC;
      S_CALC:   if (cnt == 5'd31) state_nxt = S_FINISH;
      S_FINISH: state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_arstn) begin
    if (!i_arstn) state <= S_IDLE;
    else          state <= state_nxt;
  end

  assign o_busy = (state != S_IDLE);

  always_ff @(posedge i_clk or negedge i_arstn) begin
    if (!i_arstn) begin
      cnt    <= '0;
      acc    <= '0;
      opnd   <= '0;
      a_raw  <= '0;
      ctl    <= '0;
      o_hi   <= '0;
      o_lo   <= '0;
      o_done <= 1'b0;
      o_dz   <= 1'b0;
    end else begin
      o_done <= 1'b0;
      o_dz   <= 1'b0;
      case (state)
        S_IDLE: if (i_start) begin
          if (i_op == OP_MTHI)      o_hi <= i_bus_a;
          else if (i_op == OP_MTLO) o_lo <= i_bus_a;
          else if (is_md) begin
            acc   <= {33'd0, i_op[1] ? a_mag : b_mag};
            opnd  <= i_op[1] ? b_mag : a_mag;
            a_raw <= i_bus_a;
            ctl   <= ctl_in;
            cnt   <= '0;
          end
        end
        S_CALC: begin
          acc <= acc_step;
          cnt <= cnt + 5'd1;
        end
        S_FINISH: begin
          o_done <= 1'b1;
          if (dz) begin
            // divide by zero: raw dividend to HI, all-ones to LO, no sign fix
            o_hi <= a_raw;
            o_lo <= 32'hFFFF_FFFF;
            o_dz <= 1'b1;
          end else if (ctl.is_div) begin
            o_hi <= r_fix;
            o_lo <= q_fix;
          end else begin
            {o_hi, o_lo} <= mult_res;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_hilo_muldiv.sv
// Bench for hilo_muldiv: cycle-level reference model plus directed vectors with literal results.
module tb_hilo_muldiv;
  logic        i_clk = 1'b0, i_arstn = 1'b0, i_start = 1'b0;
  logic [2:0]  i_op = 3'd0;
  logic [31:0] i_bus_a = '0, i_bus_b = '0;
  logic        o_busy, o_done, o_dz;
  logic [31:0] o_hi, o_lo;

  hilo_muldiv dut (
    .i_clk(i_clk), .i_arstn(i_arstn), .i_start(i_start), .i_op(i_op),
    .i_bus_a(i_bus_a), .i_bus_b(i_bus_b), .o_busy(o_busy), .o_done(o_done),
    .o_dz(o_dz), .o_hi(o_hi), .o_lo(o_lo)
  );

  always #5 i_clk = ~i_clk;

  int checks = 0, failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Architectural result {dz, hi, lo} from plain arithmetic
  function automatic logic [64:0] ref_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint    sp;
    logic [63:0] p;
    int        sa, sb;
    case (op)
      3'd0: begin sp = longint'($signed(a)) * longint'($signed(b)); p = 64'(sp); return {1'b0, p}; end
      3'd1: begin p = {32'd0, a} * {32'd0, b}; return {1'b0, p}; end
      default: begin
        if (b == 32'd0) return {1'b1, a, 32'hFFFF_FFFF};
        if (op == 3'd3) return {1'b0, a % b, a / b};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {1'b0, 32'd0, 32'h8000_0000};
        sa = a; sb = b;
        return {1'b0, 32'(sa % sb), 32'(sa / sb)};
      end
    endcase
  endfunction

  // Reference model: a pending result retires 33 edges after acceptance
  logic [31:0] m_hi, m_lo;
  logic        m_done, m_dz;
  int          m_cnt;
  logic [64:0] pend;

  always @(posedge i_clk or negedge i_arstn) begin
    if (!i_arstn) begin
      m_hi <= '0; m_lo <= '0; m_done <= 1'b0; m_dz <= 1'b0; m_cnt <= 0; pend <= '0;
    end else begin
      m_done <= 1'b0;
      m_dz   <= 1'b0;
      if (m_cnt != 0) begin
        m_cnt <= m_cnt - 1;
        if (m_cnt == 1) begin
          m_hi <= pend[63:32]; m_lo <= pend[31:0]; m_dz <= pend[64]; m_done <= 1'b1;
        end
      end else if (i_start) begin
        case (i_op)
          3'd4: m_hi <= i_bus_a;
          3'd5: m_lo <= i_bus_a;
          3'd0, 3'd1, 3'd2, 3'd3: begin pend <= ref_op(i_op, i_bus_a, i_bus_b); m_cnt <= 33; end
          default: ;
        endcase
      end
    end
  end

  always @(negedge i_clk) begin
    chk("cyc_busy", {31'd0, o_busy}, {31'd0, m_cnt != 0});
    chk("cyc_done", {31'd0, o_done}, {31'd0, m_done});
    chk("cyc_dz",   {31'd0, o_dz},   {31'd0, m_dz});
    chk("cyc_hi",   o_hi, m_hi);
    chk("cyc_lo",   o_lo, m_lo);
  end

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a, b, hi, lo;
    logic        dz;
  } vec_t;

  vec_t vecs[12] = '{
    '{3'd0, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0},
    '{3'd1, 32'hFFFF_FFFF, 32'h0000_0002, 32'h0000_0001, 32'hFFFF_FFFE, 1'b0},
    '{3'd2, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0},
    '{3'd3, 32'd100,       32'd7,         32'd2,         32'd14,        1'b0},
    '{3'd3, 32'h1234_5678, 32'h0000_0000, 32'h1234_5678, 32'hFFFF_FFFF, 1'b1},
    '{3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0},
    '{3'd0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0},
    '{3'd2, 32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD, 1'b0},
    '{3'd2, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'd3,         1'b0},
    '{3'd0, 32'hFFFF_FFFD, 32'hFFFF_FFF9, 32'd0,         32'd21,        1'b0},
    '{3'd2, 32'hFFFF_FFF0, 32'h0000_0000, 32'hFFFF_FFF0, 32'hFFFF_FFFF, 1'b1},
    '{3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0}
  };

  // Issue, scramble buses, then wait (bounded) for the done pulse
  task automatic run(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] ehi, input logic [31:0] elo, input logic edz, input bit poke);
    int n, nbusy;
    @(negedge i_clk);
    i_start = 1'b1; i_op = op; i_bus_a = a; i_bus_b = b;
    @(negedge i_clk);
    i_start = 1'b0; i_bus_a = ~a; i_bus_b = b ^ 32'h5A5A_5A5A;
    n = 1; nbusy = o_busy ? 1 : 0;
    while (!o_done && n < 100) begin
      @(negedge i_clk);
      n++;
      if (o_busy) nbusy++;
      if (poke && n == 10) begin i_start = 1'b1; i_op = 3'd3; i_bus_a = 32'd99; i_bus_b = 32'd5; end
      if (poke && n == 11) i_start = 1'b0;
    end
    chk("latency", n, 34);
    chk("busy_cycles", nbusy, 33);
    chk("res_hi", o_hi, ehi);
    chk("res_lo", o_lo, elo);
    chk("res_dz", {31'd0, o_dz}, {31'd0, edz});
    @(negedge i_clk);
    chk("done_width", {31'd0, o_done}, 32'd0);
    chk("dz_width", {31'd0, o_dz}, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int ndone;
    repeat (2) @(negedge i_clk);
    chk("rst_hi", o_hi, 32'd0);
    chk("rst_lo", o_lo, 32'd0);
    chk("rst_busy", {31'd0, o_busy}, 32'd0);
    chk("rst_done", {31'd0, o_done}, 32'd0);
    #2 i_arstn = 1'b1;

    foreach (vecs[i]) run(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].hi, vecs[i].lo, vecs[i].dz, 1'b0);

    // Start ignored while busy; buses changed mid-CALC
    run(3'd0, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, 1'b1);

    // MTHI then MTLO on consecutive cycles
    @(negedge i_clk); i_start = 1'b1; i_op = 3'd4; i_bus_a = 32'hDEAD_BEEF;
    @(negedge i_clk); i_op = 3'd5; i_bus_a = 32'h0BAD_F00D;
    chk("mthi", o_hi, 32'hDEAD_BEEF);
    chk("mt_busy", {31'd0, o_busy}, 32'd0);
    @(negedge i_clk); i_start = 1'b0;
    chk("mtlo", o_lo, 32'h0BAD_F00D);
    chk("mt_done", {31'd0, o_done}, 32'd0);

    // Reserved ops change nothing
    @(negedge i_clk); i_start = 1'b1; i_op = 3'd7; i_bus_a = 32'h1111_1111;
    @(negedge i_clk); i_op = 3'd6;
    @(negedge i_clk); i_start = 1'b0;
    chk("rsvd_hi", o_hi, 32'hDEAD_BEEF);
    chk("rsvd_lo", o_lo, 32'h0BAD_F00D);
    chk("rsvd_busy", {31'd0, o_busy}, 32'd0);

    // Reset in the middle of a DIVU
    @(negedge i_clk); i_start = 1'b1; i_op = 3'd3; i_bus_a = 32'd1000; i_bus_b = 32'd3;
    @(negedge i_clk); i_start = 1'b0;
    repeat (14) @(negedge i_clk);
    #2 i_arstn = 1'b0;
    #1;
    chk("abort_hi", o_hi, 32'd0);
    chk("abort_lo", o_lo, 32'd0);
    chk("abort_busy", {31'd0, o_busy}, 32'd0);
    @(negedge i_clk); #2 i_arstn = 1'b1;
    ndone = 0;
    repeat (40) begin @(negedge i_clk); if (o_done) ndone++; end
    chk("abort_no_done", ndone, 0);
    run(3'd3, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
